// File: rtl/mc_ctrl_unit.sv
// Moore multicycle control unit for the single-memory MIPS-subset datapath.
// All strobes and selectors decode from the state register; BEQ pc_load follows zero.
module mc_ctrl_unit (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       pc_load,
   output logic [2:0] pc_src_sel,
   output logic       i_or_d,
   output logic       mem_wr,
   output logic       ir_write,
   output logic       mdr_load,
   output logic       ab_load,
   output logic       alu_out_load,
   output logic       reg_write,
   output logic [2:0] reg_dst_sel,
   output logic [2:0] mem_to_reg_sel,
   output logic [2:0] alu_src_a_sel,
   output logic [2:0] alu_src_b_sel,
   output logic [2:0] alu_op,
   output logic       illegal_op,
   output logic [4:0] state_out
);

   localparam int unsigned STW = 5;
   localparam int unsigned OPW = 3;

   localparam logic [OPW-1:0] ALU_PASS = 3'b000;
   localparam logic [OPW-1:0] ALU_ADD  = 3'b001;
   localparam logic [OPW-1:0] ALU_SUB  = 3'b010;
   localparam logic [OPW-1:0] ALU_AND  = 3'b011;

   typedef enum logic [STW-1:0] {
      RST_SP  = 5'd0,  FETCH1 = 5'd1,  FETCH2 = 5'd2,  FETCH3 = 5'd3,
      DECODE  = 5'd4,  EXEC_R = 5'd5,  WB_R   = 5'd6,  EXEC_I = 5'd7,
      WB_I    = 5'd8,  ADDR   = 5'd9,  MEMRD1 = 5'd10, MEMRD2 = 5'd11,
      MEMRD3  = 5'd12, WB_LW  = 5'd13, MEMWR  = 5'd14, BRANCH = 5'd15,
      JUMP    = 5'd16, ILLEGAL = 5'd17
   } state_t;

   state_t         state, state_nx;
   logic [OPW-1:0] r_op, r_op_nx;

   // State register plus the R-type ALU operation captured at DECODE
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RST_SP;
         r_op  <= ALU_PASS;
      end else begin
         state <= state_nx;
         r_op  <= r_op_nx;
      end
   end

   // Next-state and output decode
   always_comb begin
      state_nx       = state;
      r_op_nx        = r_op;
      pc_load        = 1'b0;
      pc_src_sel     = 3'd0;
      i_or_d         = 1'b0;
      mem_wr         = 1'b0;
      ir_write       = 1'b0;
      mdr_load       = 1'b0;
      ab_load        = 1'b0;
      alu_out_load   = 1'b0;
      reg_write      = 1'b0;
      reg_dst_sel    = 3'd0;
      mem_to_reg_sel = 3'd0;
      alu_src_a_sel  = 3'd0;
      alu_src_b_sel  = 3'd0;
      alu_op         = ALU_PASS;
      illegal_op     = 1'b0;
      state_out      = state;

      case (state)
         RST_SP: begin
            reg_write      = 1'b1;
            reg_dst_sel    = 3'd2;
            mem_to_reg_sel = 3'd2;
            state_nx       = FETCH1;
         end
         FETCH1: begin
            alu_src_b_sel = 3'd1;
            alu_op        = ALU_ADD;
            state_nx      = FETCH2;
         end
         FETCH2: begin
            alu_src_b_sel = 3'd1;
            alu_op        = ALU_ADD;
            state_nx      = FETCH3;
         end
         FETCH3: begin
            alu_src_b_sel = 3'd1;
            alu_op        = ALU_ADD;
            ir_write      = 1'b1;
            pc_load       = 1'b1;
            state_nx      = DECODE;
         end
         DECODE: begin
            ab_load       = 1'b1;
            alu_out_load  = 1'b1;
            alu_src_b_sel = 3'd3;
            alu_op        = ALU_ADD;
            case (opcode)
               6'h00: begin
                  state_nx = EXEC_R;
                  case (funct)
                     6'h20:   r_op_nx = ALU_ADD;
                     6'h22:   r_op_nx = ALU_SUB;
                     6'h24:   r_op_nx = ALU_AND;
                     default: state_nx = ILLEGAL;
                  endcase
               end
               6'h08:        state_nx = EXEC_I;
               6'h23, 6'h2B: state_nx = ADDR;
               6'h04:        state_nx = BRANCH;
               6'h02:        state_nx = JUMP;
               default:      state_nx = ILLEGAL;
            endcase
         end
         EXEC_R: begin
            alu_src_a_sel = 3'd1;
            alu_op        = r_op;
            alu_out_load  = 1'b1;
            state_nx      = WB_R;
         end
         WB_R: begin
            reg_write   = 1'b1;
            reg_dst_sel = 3'd1;
            state_nx    = FETCH1;
         end
         EXEC_I, ADDR: begin
            alu_src_a_sel = 3'd1;
            alu_src_b_sel = 3'd2;
            alu_op        = ALU_ADD;
            alu_out_load  = 1'b1;
            if (state == EXEC_I)      state_nx = WB_I;
            else if (opcode == 6'h2B) state_nx = MEMWR;
            else                      state_nx = MEMRD1;
         end
         WB_I: begin
            reg_write = 1'b1;
            state_nx  = FETCH1;
         end
         MEMRD1: begin
            i_or_d   = 1'b1;
            state_nx = MEMRD2;
         end
         MEMRD2: begin
            i_or_d   = 1'b1;
            state_nx = MEMRD3;
         end
         MEMRD3: begin
            i_or_d   = 1'b1;
            mdr_load = 1'b1;
            state_nx = WB_LW;
         end
         WB_LW: begin
            reg_write      = 1'b1;
            mem_to_reg_sel = 3'd1;
            state_nx       = FETCH1;
         end
         MEMWR: begin
            i_or_d   = 1'b1;
            mem_wr   = 1'b1;
            state_nx = FETCH1;
         end
         BRANCH: begin
            alu_src_a_sel = 3'd1;
            alu_op        = ALU_SUB;
            pc_src_sel    = 3'd1;
            pc_load       = zero;
            state_nx      = FETCH1;
         end
         JUMP: begin
            pc_load    = 1'b1;
            pc_src_sel = 3'd2;
            state_nx   = FETCH1;
         end
         ILLEGAL: begin
            illegal_op = 1'b1;
            state_nx   = FETCH1;
         end
         default: state_nx = RST_SP;
      endcase
   end

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Directed bench for mc_ctrl_unit: per-cycle vector table plus instruction-level sequences.
module tb_mc_ctrl_unit;

   localparam logic [4:0] S_RST = 5'd0,  S_F1 = 5'd1,  S_F2 = 5'd2,  S_F3 = 5'd3,
                          S_DEC = 5'd4,  S_EXR = 5'd5, S_WBR = 5'd6, S_EXI = 5'd7,
                          S_WBI = 5'd8,  S_ADR = 5'd9, S_M1 = 5'd10, S_M2 = 5'd11,
                          S_M3 = 5'd12,  S_WBL = 5'd13, S_MW = 5'd14, S_BR = 5'd15,
                          S_J = 5'd16,   S_ILL = 5'd17;

   typedef struct packed {
      logic       pcl;
      logic [2:0] pcs;
      logic       iod, mw, irw, mdr, ab, aol, rw;
      logic [2:0] dst, m2r, sa, sb, op;
      logic       ill;
      logic [4:0] st;
   } outs_t;

   typedef struct {
      logic       rst;
      logic [5:0] opc, fn;
      logic       z;
      logic [4:0] st;
      logic [2:0] op;
      logic       pcl;
   } vec_t;

   logic clk = 1'b0;
   logic reset, zero;
   logic [5:0] opcode, funct;
   logic pc_load, i_or_d, mem_wr, ir_write, mdr_load, ab_load, alu_out_load, reg_write, illegal_op;
   logic [2:0] pc_src_sel, reg_dst_sel, mem_to_reg_sel, alu_src_a_sel, alu_src_b_sel, alu_op;
   logic [4:0] state_out;
   outs_t act;

   int total = 0;
   int bad   = 0;
   vec_t vq[$];

   always #5 clk = ~clk;

   mc_ctrl_unit dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
      .pc_load(pc_load), .pc_src_sel(pc_src_sel), .i_or_d(i_or_d), .mem_wr(mem_wr),
      .ir_write(ir_write), .mdr_load(mdr_load), .ab_load(ab_load),
      .alu_out_load(alu_out_load), .reg_write(reg_write), .reg_dst_sel(reg_dst_sel),
      .mem_to_reg_sel(mem_to_reg_sel), .alu_src_a_sel(alu_src_a_sel),
      .alu_src_b_sel(alu_src_b_sel), .alu_op(alu_op), .illegal_op(illegal_op),
      .state_out(state_out)
   );

   assign act = {pc_load, pc_src_sel, i_or_d, mem_wr, ir_write, mdr_load, ab_load,
                 alu_out_load, reg_write, reg_dst_sel, mem_to_reg_sel, alu_src_a_sel,
                 alu_src_b_sel, alu_op, illegal_op, state_out};

   // Hand-written per-state drive table; alu_op and pc_load are given per vector
   function automatic outs_t expv(logic [4:0] st, logic [2:0] op, logic pcl);
      outs_t e = '0;
      e.st = st; e.op = op; e.pcl = pcl;
      case (st)
         S_RST: begin e.rw = 1; e.dst = 3'd2; e.m2r = 3'd2; end
         S_F1, S_F2: e.sb = 3'd1;
         S_F3:  begin e.sb = 3'd1; e.irw = 1; end
         S_DEC: begin e.ab = 1; e.aol = 1; e.sb = 3'd3; end
         S_EXR: begin e.sa = 3'd1; e.aol = 1; end
         S_WBR: begin e.rw = 1; e.dst = 3'd1; end
         S_EXI, S_ADR: begin e.sa = 3'd1; e.sb = 3'd2; e.aol = 1; end
         S_WBI: e.rw = 1;
         S_M1, S_M2: e.iod = 1;
         S_M3:  begin e.iod = 1; e.mdr = 1; end
         S_WBL: begin e.rw = 1; e.m2r = 3'd1; end
         S_MW:  begin e.iod = 1; e.mw = 1; end
         S_BR:  begin e.sa = 3'd1; e.pcs = 3'd1; end
         S_J:   e.pcs = 3'd2;
         S_ILL: e.ill = 1;
         default: ;
      endcase
      return e;
   endfunction

   task automatic check(string name, outs_t exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic checkv(string name, int got, int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic add(logic r, logic [5:0] o, logic [5:0] f, logic z,
                      logic [4:0] s, logic [2:0] op, logic pcl);
      vec_t v;
      v.rst = r; v.opc = o; v.fn = f; v.z = z; v.st = s; v.op = op; v.pcl = pcl;
      vq.push_back(v);
   endtask

   // Fetch prefix (FETCH1 already reached) through DECODE
   task automatic add_fetch(logic [5:0] o, logic [5:0] f, logic z);
      add(0, o, f, z, S_F2, 3'd1, 0);
      add(0, o, f, z, S_F3, 3'd1, 1);
      add(0, o, f, z, S_DEC, 3'd1, 0);
   endtask

   // Run one instruction from FETCH1 until FETCH1 recurs, bounded at 20 cycles
   task automatic run_instr(logic [5:0] o, logic [5:0] f, logic z, output int n,
                            output int mw, output int irw, output int ill,
                            output int pcl, output int rw);
      n = 0; mw = 0; irw = 0; ill = 0; pcl = 0; rw = 0;
      opcode = o; funct = f; zero = z;
      do begin
         mw += int'(mem_wr); irw += int'(ir_write); ill += int'(illegal_op);
         rw += int'(reg_write);
         if (state_out != S_F3) pcl += int'(pc_load);
         n++;
         step();
      end while (state_out != S_F1 && n < 20);
   endtask

   initial begin
      int n, mw, irw, ill, pcl, rw;
      reset = 1; opcode = '0; funct = '0; zero = 0;

      for (int i = 0; i < 3; i++) begin
         step();
         check("reset_hold", expv(S_RST, 3'd0, 0));
      end
      reset = 0;
      #1 check("reset_release", expv(S_RST, 3'd0, 0));

      add(0, 6'h00, 6'h22, 0, S_F1, 3'd1, 0);
      add_fetch(6'h00, 6'h22, 0);
      add(0, 6'h00, 6'h22, 0, S_EXR, 3'd2, 0);
      add(0, 6'h00, 6'h22, 0, S_WBR, 3'd0, 0);
      add(0, 6'h00, 6'h22, 0, S_F1, 3'd1, 0);
      add_fetch(6'h23, 6'h00, 0);
      add(0, 6'h23, 6'h00, 0, S_ADR, 3'd1, 0);
      add(0, 6'h23, 6'h00, 0, S_M1, 3'd0, 0);
      add(0, 6'h23, 6'h00, 0, S_M2, 3'd0, 0);
      add(0, 6'h23, 6'h00, 0, S_M3, 3'd0, 0);
      add(0, 6'h23, 6'h00, 0, S_WBL, 3'd0, 0);
      add(0, 6'h23, 6'h00, 0, S_F1, 3'd1, 0);
      add_fetch(6'h2B, 6'h00, 0);
      add(0, 6'h2B, 6'h00, 0, S_ADR, 3'd1, 0);
      add(0, 6'h2B, 6'h00, 0, S_MW, 3'd0, 0);
      add(0, 6'h2B, 6'h00, 0, S_F1, 3'd1, 0);
      add_fetch(6'h04, 6'h00, 1);
      add(0, 6'h04, 6'h00, 1, S_BR, 3'd2, 1);
      add(0, 6'h04, 6'h00, 1, S_F1, 3'd1, 0);
      add_fetch(6'h04, 6'h00, 0);
      add(0, 6'h04, 6'h00, 0, S_BR, 3'd2, 0);
      add(0, 6'h04, 6'h00, 0, S_F1, 3'd1, 0);
      add_fetch(6'h3F, 6'h00, 0);
      add(0, 6'h3F, 6'h00, 0, S_ILL, 3'd0, 0);
      add(0, 6'h3F, 6'h00, 0, S_F1, 3'd1, 0);
      add_fetch(6'h00, 6'h2A, 0);
      add(0, 6'h00, 6'h2A, 0, S_ILL, 3'd0, 0);
      add(0, 6'h00, 6'h2A, 0, S_F1, 3'd1, 0);
      add_fetch(6'h08, 6'h00, 1);
      add(0, 6'h08, 6'h00, 1, S_EXI, 3'd1, 0);
      add(0, 6'h08, 6'h00, 1, S_WBI, 3'd0, 0);
      add(0, 6'h08, 6'h00, 1, S_F1, 3'd1, 0);
      add_fetch(6'h02, 6'h00, 0);
      add(0, 6'h02, 6'h00, 0, S_J, 3'd0, 1);
      add(0, 6'h02, 6'h00, 0, S_F1, 3'd1, 0);
      add_fetch(6'h00, 6'h20, 0);
      add(0, 6'h00, 6'h20, 0, S_EXR, 3'd1, 0);
      add(0, 6'h00, 6'h20, 0, S_WBR, 3'd0, 0);
      add(0, 6'h00, 6'h20, 0, S_F1, 3'd1, 0);
      add_fetch(6'h00, 6'h24, 0);
      add(0, 6'h00, 6'h24, 0, S_EXR, 3'd3, 0);
      add(0, 6'h00, 6'h24, 0, S_WBR, 3'd0, 0);
      add(0, 6'h00, 6'h24, 0, S_F1, 3'd1, 0);
      // lw interrupted by reset in MEMRD2
      add_fetch(6'h23, 6'h00, 0);
      add(0, 6'h23, 6'h00, 0, S_ADR, 3'd1, 0);
      add(0, 6'h23, 6'h00, 0, S_M1, 3'd0, 0);
      add(0, 6'h23, 6'h00, 0, S_M2, 3'd0, 0);
      add(1, 6'h23, 6'h00, 0, S_RST, 3'd0, 0);
      add(0, 6'h23, 6'h00, 0, S_F1, 3'd1, 0);
      // sw interrupted by reset in MEMWR
      add_fetch(6'h2B, 6'h00, 0);
      add(0, 6'h2B, 6'h00, 0, S_ADR, 3'd1, 0);
      add(0, 6'h2B, 6'h00, 0, S_MW, 3'd0, 0);
      add(1, 6'h2B, 6'h00, 0, S_RST, 3'd0, 0);
      add(1, 6'h2B, 6'h00, 0, S_RST, 3'd0, 0);
      add(0, 6'h2B, 6'h00, 0, S_F1, 3'd1, 0);

      foreach (vq[i]) begin
         reset = vq[i].rst; opcode = vq[i].opc; funct = vq[i].fn; zero = vq[i].z;
         step();
         check($sformatf("vec%0d", i), expv(vq[i].st, vq[i].op, vq[i].pcl));
      end

      // zero toggling outside BRANCH must not move pc_load
      zero = 1;
      #1 check("zero_ignored_f1", expv(S_F1, 3'd1, 0));

      run_instr(6'h2B, 6'h00, 0, n, mw, irw, ill, pcl, rw);
      checkv("sw_cycles", n, 6);
      checkv("sw_mem_wr", mw, 1);
      checkv("sw_ir_write", irw, 1);

      run_instr(6'h3F, 6'h00, 0, n, mw, irw, ill, pcl, rw);
      checkv("ill_cycles", n, 5);
      checkv("ill_pulse", ill, 1);
      checkv("ill_side_effects", mw + pcl + rw, 0);

      run_instr(6'h23, 6'h00, 1, n, mw, irw, ill, pcl, rw);
      checkv("lw_cycles", n, 9);
      checkv("lw_ir_write", irw, 1);

      run_instr(6'h04, 6'h00, 0, n, mw, irw, ill, pcl, rw);
      checkv("beq_nt_cycles", n, 5);
      checkv("beq_nt_pc_load", pcl, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
